// File: rtl/pwm_sequencer.sv
// Multi-channel PWM generator with a prescaled period counter and a double-buffered
// threshold load sequence that swaps new duty values in only at a period wrap.
//
// state | meaning
// IDLE  | no load in progress; waits for a wrap with a commit pending
// LATCH | one-cycle swap strobe to the threshold memory, clears pending
// LOAD  | reads one threshold per clock into the staging registers
// READY | staging holds the new set; applied to active[] at the next wrap
module pwm_sequencer #(
    parameter int pwm_width      = 16,
    parameter int num_pwm        = 4,
    parameter int prescale_width = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [prescale_width-1:0]     prescale,
    input  logic [pwm_width-1:0]          period,
    input  logic                          commit,
    output logic                          busy,
    output logic                          latch_mem,
    output logic [$clog2(num_pwm)-1:0]    raddr,
    input  logic [pwm_width-1:0]          rdata,
    output logic [num_pwm-1:0]            pwm_out,
    output logic                          period_start,
    output logic                          overrun
);

    localparam int aw = $clog2(num_pwm);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LATCH = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_READY = 2'd3;

    localparam logic [aw-1:0] last_idx = aw'(num_pwm - 1);

    logic [prescale_width-1:0] psc;
    logic [pwm_width-1:0]      cnt;
    logic                      tick;
    logic                      wrap;
    logic [1:0]                state;
    logic [aw-1:0]             idx;
    logic                      pending;
    logic [pwm_width-1:0]      staging [num_pwm];
    logic [pwm_width-1:0]      active  [num_pwm];

    assign tick = enable && (psc == prescale);
    assign wrap = tick && (cnt == period);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc <= '0;
        end else if (!enable || tick) begin
            psc <= '0;
        end else begin
            psc <= psc + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!enable || wrap) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_start <= 1'b0;
            pwm_out      <= '0;
        end else begin
            period_start <= wrap;
            for (int i = 0; i < num_pwm; i++) begin
                pwm_out[i] <= enable && (cnt < active[i]);
            end
        end
    end

    // A wrap that lands while the load is still in flight cannot transfer the
    // new set; it is flagged and the transfer waits for the following wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
            for (int i = 0; i < num_pwm; i++) begin
                staging[i] <= '0;
                active[i]  <= '0;
            end
        end else begin
            if (wrap && ((state == ST_LATCH) || (state == ST_LOAD))) begin
                overrun <= 1'b1;
            end
            if (commit) begin
                pending <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (wrap && (pending || commit)) begin
                        state <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    pending <= 1'b0;
                    idx     <= '0;
                    state   <= ST_LOAD;
                end
                ST_LOAD: begin
                    staging[idx] <= rdata;
                    if (idx == last_idx) begin
                        idx   <= '0;
                        state <= ST_READY;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    if (wrap) begin
                        for (int i = 0; i < num_pwm; i++) begin
                            active[i] <= staging[i];
                        end
                        state <= (pending || commit) ? ST_LATCH : ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign latch_mem = (state == ST_LATCH);
    assign raddr     = (state == ST_LOAD) ? idx : '0;
    assign busy      = pending || (state != ST_IDLE);

endmodule

// File: tb/tb_pwm_sequencer.sv
// Directed bench for pwm_sequencer: a double-buffered threshold memory model feeds
// the load sequence, and per-period high counts are compared with hand-derived values.
module tb_pwm_sequencer;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [7:0]  prescale;
    logic [15:0] period;
    logic        commit;
    logic        busy;
    logic        latch_mem;
    logic [1:0]  raddr;
    logic [15:0] rdata;
    logic [3:0]  pwm_out;
    logic        period_start;
    logic        overrun;

    int vectors = 0;
    int errors  = 0;
    int hi [4];
    int latch_cnt;
    int ps_cnt;
    int expv [4];

    logic [15:0] wr_buf [4];
    logic [15:0] rd_buf [4];

    pwm_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .prescale     (prescale),
        .period       (period),
        .commit       (commit),
        .busy         (busy),
        .latch_mem    (latch_mem),
        .raddr        (raddr),
        .rdata        (rdata),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Host-side buffer is swapped into the read side on the latch strobe.
    always @(posedge clk) begin
        if (latch_mem) begin
            for (int i = 0; i < 4; i++) rd_buf[i] <= wr_buf[i];
        end
    end
    assign rdata = rd_buf[raddr];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_ps(input int limit);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < limit);
        if (!period_start) begin
            vectors++;
            errors++;
            $display("FAIL wait_ps: no period_start within %0d cycles", limit);
        end
    endtask

    task automatic count_window(input int n);
        for (int i = 0; i < 4; i++) hi[i] = 0;
        latch_cnt = 0;
        ps_cnt    = 0;
        repeat (n) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (pwm_out[i]) hi[i]++;
            if (latch_mem) latch_cnt++;
            if (period_start) ps_cnt++;
        end
    endtask

    task automatic restart(input logic [7:0] p, input logic [15:0] per);
        enable = 1'b0;
        @(negedge clk);
        prescale = p;
        period   = per;
        @(negedge clk);
        enable = 1'b1;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; commit = 1'b0; prescale = 8'd0; period = 16'd9;
        repeat (3) @(negedge clk);
        vectors++;
        if ({pwm_out, latch_mem, period_start, busy, raddr, overrun} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0", {pwm_out, latch_mem, period_start, busy, raddr, overrun});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        wr_buf = '{16'd0, 16'd3, 16'd9, 16'd10};
        enable = 1'b1;
        pulse_commit();
        vectors++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
        wait_ps(50);
        vectors++;
        if (latch_mem !== 1'b1) begin errors++; $display("FAIL basic_latch: got %b expected 1", latch_mem); end
        count_window(10);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (hi[i] != 0) begin errors++; $display("FAIL basic_old_ch%0d: got %0d expected 0", i, hi[i]); end
        end
        vectors++;
        if (ps_cnt != 1 || latch_cnt != 0) begin
            errors++; $display("FAIL basic_pulses: got ps=%0d latch=%0d expected ps=1 latch=0", ps_cnt, latch_cnt);
        end
        count_window(10);
        expv = '{0, 3, 9, 10};
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (hi[i] != expv[i]) begin errors++; $display("FAIL basic_new_ch%0d: got %0d expected %0d", i, hi[i], expv[i]); end
        end
        vectors++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_prescaler();
        wr_buf = '{16'd2, 16'd0, 16'd4, 16'd1};
        restart(8'd2, 16'd3);
        pulse_commit();
        wait_ps(100);
        vectors++;
        if (latch_mem !== 1'b1) begin errors++; $display("FAIL psc_latch: got %b expected 1", latch_mem); end
        count_window(12);
        vectors++;
        if (ps_cnt != 1 || period_start !== 1'b1) begin
            errors++; $display("FAIL psc_interval: got ps=%0d last=%b expected ps=1 last=1", ps_cnt, period_start);
        end
        count_window(12);
        expv = '{6, 0, 12, 3};
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (hi[i] != expv[i]) begin errors++; $display("FAIL psc_ch%0d: got %0d expected %0d", i, hi[i], expv[i]); end
        end
    endtask

    task automatic test_duplicate_commit();
        wr_buf = '{16'd1, 16'd2, 16'd3, 16'd4};
        restart(8'd0, 16'd9);
        pulse_commit();
        @(negedge clk);
        pulse_commit();
        vectors++;
        if (busy !== 1'b1) begin errors++; $display("FAIL dup_busy: got %b expected 1", busy); end
        wait_ps(50);
        vectors++;
        if (latch_mem !== 1'b1) begin errors++; $display("FAIL dup_latch: got %b expected 1", latch_mem); end
        count_window(10);
        vectors++;
        if (latch_cnt != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL dup_single: got latch=%0d busy=%b expected latch=0 busy=0", latch_cnt, busy);
        end
        count_window(10);
        expv = '{1, 2, 3, 4};
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (hi[i] != expv[i]) begin errors++; $display("FAIL dup_ch%0d: got %0d expected %0d", i, hi[i], expv[i]); end
        end
        vectors++;
        if (latch_cnt != 0) begin errors++; $display("FAIL dup_extra_latch: got %0d expected 0", latch_cnt); end
    endtask

    task automatic test_overrun();
        wr_buf = '{16'd0, 16'd1, 16'd3, 16'd2};
        restart(8'd0, 16'd2);
        pulse_commit();
        wait_ps(20);
        vectors++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_before: got %b expected 0", overrun); end
        wait_ps(20);
        vectors++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", overrun); end
        count_window(3);
        expv = '{1, 2, 3, 3};
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (hi[i] != expv[i]) begin errors++; $display("FAIL ovr_old_ch%0d: got %0d expected %0d", i, hi[i], expv[i]); end
        end
        count_window(3);
        expv = '{0, 1, 3, 2};
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (hi[i] != expv[i]) begin errors++; $display("FAIL ovr_new_ch%0d: got %0d expected %0d", i, hi[i], expv[i]); end
        end
        vectors++;
        if (overrun !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL ovr_sticky: got overrun=%b busy=%b expected 1 0", overrun, busy);
        end
    endtask

    task automatic test_enable_gating();
        int n;
        restart(8'd0, 16'd9);
        wait_ps(50);
        repeat (2) @(negedge clk);
        vectors++;
        if (pwm_out !== 4'b1100) begin errors++; $display("FAIL gate_running: got %b expected 1100", pwm_out); end
        enable = 1'b0;
        @(negedge clk);
        vectors++;
        if (pwm_out !== 4'b0000) begin errors++; $display("FAIL gate_off: got %b expected 0000", pwm_out); end
        count_window(20);
        vectors++;
        if (ps_cnt != 0 || (hi[0] + hi[1] + hi[2] + hi[3]) != 0) begin
            errors++; $display("FAIL gate_hold: got ps=%0d highs=%0d expected 0 0", ps_cnt, hi[0] + hi[1] + hi[2] + hi[3]);
        end
        enable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < 50);
        vectors++;
        if (n != 10) begin errors++; $display("FAIL gate_restart: got first period_start after %0d clocks expected 10", n); end
        vectors++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL gate_overrun_sticky: got %b expected 1", overrun); end
    endtask

    task automatic test_reset_mid_load();
        wr_buf = '{16'd7, 16'd7, 16'd7, 16'd7};
        pulse_commit();
        wait_ps(50);
        vectors++;
        if (latch_mem !== 1'b1) begin errors++; $display("FAIL rload_latch: got %b expected 1", latch_mem); end
        repeat (3) @(negedge clk);
        vectors++;
        if (raddr !== 2'd2) begin errors++; $display("FAIL rload_raddr: got %0d expected 2", raddr); end
        rst = 1'b1;
        #1;
        vectors++;
        if ({pwm_out, latch_mem, period_start, busy, raddr, overrun} !== 10'b0) begin
            errors++;
            $display("FAIL rload_outputs: got %b expected 0", {pwm_out, latch_mem, period_start, busy, raddr, overrun});
        end
        @(negedge clk);
        rst = 1'b0;
        count_window(30);
        vectors++;
        if (latch_cnt != 0 || ps_cnt != 3) begin
            errors++; $display("FAIL rload_after: got latch=%0d ps=%0d expected latch=0 ps=3", latch_cnt, ps_cnt);
        end
        vectors++;
        if ((hi[0] + hi[1] + hi[2] + hi[3]) != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL rload_active: got highs=%0d busy=%b expected 0 0", hi[0] + hi[1] + hi[2] + hi[3], busy);
        end
    endtask

    task automatic test_commit_on_wrap();
        wr_buf = '{16'd2, 16'd4, 16'd6, 16'd8};
        wait_ps(50);
        repeat (9) @(negedge clk);
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        vectors++;
        if (period_start !== 1'b1 || latch_mem !== 1'b1) begin
            errors++; $display("FAIL cow_latch: got ps=%b latch=%b expected 1 1", period_start, latch_mem);
        end
        count_window(10);
        vectors++;
        if ((hi[0] + hi[1] + hi[2] + hi[3]) != 0) begin
            errors++; $display("FAIL cow_old: got highs=%0d expected 0", hi[0] + hi[1] + hi[2] + hi[3]);
        end
        count_window(10);
        expv = '{2, 4, 6, 8};
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (hi[i] != expv[i]) begin errors++; $display("FAIL cow_ch%0d: got %0d expected %0d", i, hi[i], expv[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_prescaler();
        test_duplicate_commit();
        test_overrun();
        test_enable_gating();
        test_reset_mid_load();
        test_commit_on_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
